if_fetch: RTL
=============

Name: if_fetch

Overview:
- Fetch-side consumer of the pipeline controller's redirect/stall interface: jmp_en/jmp_to, pc_hold_n, hold_n.
- Owns the architectural PC and issues single-outstanding instruction reads (req/ack) to instruction memory.
- Presents fetched instructions to the IF/ID boundary through an output register plus a 1-entry skid buffer.
- Flushes wrong-path fetches on jump.

Parameters:
- ADDR_W, 32, PC/memory address width.
- INST_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INST, 32'h0000_0013, value driven on inst_o when no valid instruction.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on clk rising edge.
- jmp_en_i  in  1  redirect request from ctrl.
- jmp_to_i  in  ADDR_W  redirect target.
- pc_hold_n  in  1  low: do not start new fetches, PC frozen.
- hold_n  in  1  low: IF/ID output register stalled.
- mem_req_o  out  1  fetch request.
- mem_addr_o  out  ADDR_W  fetch address; stable while mem_req_o high.
- mem_ack_i  in  1  request accepted; mem_rdata_i valid this cycle.
- mem_rdata_i  in  INST_W  instruction data.
- pc_o  out  ADDR_W  PC of inst_o.
- inst_o  out  INST_W  instruction to decode.
- inst_valid_o  out  1  inst_o/pc_o valid.

Behaviour:
- Reset (rst_n low at clk edge):
  - pc=RESET_PC, state=IDLE, mem_req_o=0, mem_addr_o=RESET_PC.
  - pc_o=0, inst_o=NOP_INST, inst_valid_o=0.
  - Skid buffer empty, kill=0, pend_jmp=0.
  - Reset mid-request abandons it; a later stray mem_ack_i is ignored while IDLE.
- States: IDLE, REQ.
  - IDLE->REQ when pc_hold_n=1, hold_n=1 and skid empty; mem_req_o=1 and mem_addr_o=pc from the next cycle.
  - First request is asserted the cycle after the first edge with rst_n high.
  - REQ holds mem_req_o/mem_addr_o constant until mem_ack_i.
  - On ack: pc<=pc+4 (modulo 2^ADDR_W, wraps). Go back to IDLE if pc_hold_n=0, hold_n=0 or skid becomes full; otherwise stay in REQ with the new address (back-to-back, 1 fetch/cycle at zero memory latency).
- Jump (jmp_en_i=1):
  - IDLE: pc<=jmp_to_i immediately.
  - REQ, no ack this cycle: latch pend_jmp/target and set kill. Address stays unchanged. When the ack arrives, data is discarded, pc<=latched target, kill/pend_jmp cleared.
  - REQ, ack in the same cycle: data discarded, pc<=jmp_to_i.
  - A second jump while pend_jmp is set overwrites the target (latest wins).
  - Every jump also clears inst_valid_o (inst_o<=NOP_INST) and empties the skid buffer on that edge.
  - Jump has priority over hold_n and pc_hold_n for PC/flush updates.
- Output stage (evaluated only if no jump):
  - hold_n=1: output register loads skid contents if the skid is full (skid then empties); else loads accepted non-killed ack data with the PC that was fetched; else inst_valid_o<=0, inst_o<=NOP_INST.
  - hold_n=0: output register unchanged. A non-killed ack goes into the skid buffer.
  - Skid full implies no new request, so there is no overflow.
- pc_hold_n=0 never aborts a request already in REQ; it only blocks the next one.
- Latency: ack at cycle N -> inst_valid_o=1 at N+1 (hold_n=1, no skid).

Optional Feature:
- IF_ALIGN_CHECK_EN.
  - Defined:
    - Adds output misalign_o (1 bit, reset 0). A jump whose jmp_to_i[1:0]!=0 sets misalign_o=1 for exactly one cycle.
    - The PC loads {jmp_to_i[ADDR_W-1:2],2'b00}.
    - misalign_o is asserted the cycle after jmp_en_i.
  - Undefined: no port; the target is loaded unmodified.

Test Plan:
- Reset release, mem_ack_i tied 1, hold signals 1 -> mem_addr_o 0x0,0x4,0x8 on consecutive cycles; inst_valid_o=1 from cycle 2 with pc_o trailing mem_addr_o by one cycle.
- Request at 0x8 with ack delayed 3 cycles; jmp_en_i=1, jmp_to_i=0x100 on the first wait cycle -> mem_addr_o stays 0x8 until ack; data 0xDEADBEEF is never output; next mem_addr_o=0x100; inst_valid_o=0 the cycle after the jump.
- hold_n=0 while a request is outstanding, ack with 0x00A00093 -> output unchanged, skid holds 0x00A00093, no new req. hold_n=1 -> inst_o=0x00A00093 next cycle, fetch resumes.
- pc_hold_n=0 in IDLE for 4 cycles -> mem_req_o=0, PC unchanged. Release -> request at the frozen PC.
- jmp_en_i together with mem_ack_i, jmp_to_i=0x40 -> ack data dropped, next mem_addr_o=0x40.
- IF_ALIGN_CHECK_EN: jump to 0x102 -> misalign_o=1 for one cycle, mem_addr_o=0x100.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, issues single-outstanding req/ack reads and
// hands instructions to decode through an output register backed by a 1-entry skid.
// Optional build macro IF_ALIGN_CHECK_EN adds misalign_o and word-aligns jump targets.
module if_fetch #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INST_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [INST_W-1:0]  NOP_INST = INST_W'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jmp_en_i,
  input  logic [ADDR_W-1:0] jmp_to_i,
  input  logic              pc_hold_n,
  input  logic              hold_n,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [INST_W-1:0] mem_rdata_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic              inst_valid_o
`ifdef IF_ALIGN_CHECK_EN
  , output logic            misalign_o
`endif
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              pend_q, pend_d;   // pending jump: in-flight fetch is wrong-path
  logic [ADDR_W-1:0] jmp_tgt;
  logic              ack_seen, ack_ok;

  logic              skid_full_q;
  logic [ADDR_W-1:0] skid_pc_q;
  logic [INST_W-1:0] skid_inst_q;

`ifdef IF_ALIGN_CHECK_EN
  assign jmp_tgt = {jmp_to_i[ADDR_W-1:2], 2'b00};
`else
  assign jmp_tgt = jmp_to_i;
`endif

  assign ack_seen   = (state_q == REQ) && mem_ack_i;
  assign ack_ok     = ack_seen && !pend_q && !jmp_en_i;
  assign mem_req_o  = (state_q == REQ);
  assign mem_addr_o = pc_q;   // pc_q only moves on ack while in REQ, so the address is stable

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      IDLE: begin
        if (jmp_en_i) pc_d = jmp_tgt;
        if (pc_hold_n && hold_n && (!skid_full_q || jmp_en_i)) state_d = REQ;
      end
      REQ: begin
        if (ack_seen) begin
          if (jmp_en_i)    pc_d = jmp_tgt;
          else if (pend_q) pc_d = tgt_q;
          else             pc_d = pc_q + ADDR_W'(4);
          pend_d = 1'b0;
          if (!pc_hold_n || !hold_n) state_d = IDLE;
        end else if (jmp_en_i) begin
          pend_d = 1'b1;
          tgt_d  = jmp_tgt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_o         <= '0;
      inst_o       <= NOP_INST;
      inst_valid_o <= 1'b0;
      skid_full_q  <= 1'b0;
    end else if (jmp_en_i) begin
      inst_o       <= NOP_INST;
      inst_valid_o <= 1'b0;
      skid_full_q  <= 1'b0;
    end else if (hold_n) begin
      if (skid_full_q) begin
        pc_o         <= skid_pc_q;
        inst_o       <= skid_inst_q;
        inst_valid_o <= 1'b1;
        skid_full_q  <= 1'b0;
      end else if (ack_ok) begin
        pc_o         <= pc_q;
        inst_o       <= mem_rdata_i;
        inst_valid_o <= 1'b1;
      end else begin
        inst_o       <= NOP_INST;
        inst_valid_o <= 1'b0;
      end
    end else if (ack_ok) begin
      skid_full_q <= 1'b1;
    end
  end

  // NOTE: payload registers are qualified by their valid flags, so they carry no reset.
  always_ff @(posedge clk) begin
    tgt_q <= tgt_d;
    if (!jmp_en_i && !hold_n && ack_ok) begin
      skid_pc_q   <= pc_q;
      skid_inst_q <= mem_rdata_i;
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) misalign_o <= 1'b0;
    else        misalign_o <= jmp_en_i && (jmp_to_i[1:0] != 2'b00);
  end
`endif

endmodule
